eth_pkt_fifo: RTL and testbench

ETH_PKT_FIFO -- requirements
Module: eth_pkt_fifo

---
 rtl/eth_pkt_fifo.sv | 105 ++++++++++
 tb/tb_eth_pkt_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_fifo.sv
// Frame-aware packet FIFO: words are written as pending, become readable only on commit,
// and are discarded on drop or when the frame overflows the buffer.
module eth_pkt_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned AFULL_TH = (1 << ADDR_W) - 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_write,
   input  logic              i_commit,
   input  logic              i_drop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_rvalid,
   input  logic              i_read,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_afull,
   output logic [ADDR_W:0]   o_used,
   output logic              o_frame_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef logic [ADDR_W:0] ptr_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   ptr_t              wr_q, wr_d;
   ptr_t              cm_q, cm_d;
   ptr_t              rd_q, rd_d;
   logic              ovf_q, ovf_d;
   logic              ferr_q, ferr_d;
   logic              rvalid_q;
   logic [DATA_W-1:0] data_q;

   ptr_t stored;
   ptr_t used;
   logic wr_acc, rd_acc, ovf_now, cm_rej;

   // One extra pointer bit distinguishes a full buffer from an empty one.
   assign stored      = wr_q - rd_q;
   assign used        = cm_q - rd_q;
   assign o_full      = (stored == ptr_t'(DEPTH));
   assign o_empty     = (used == '0);
   assign o_afull     = (stored >= ptr_t'(AFULL_TH));
   assign o_used      = used;
   assign o_data      = data_q;
   assign o_rvalid    = rvalid_q;
   assign o_frame_err = ferr_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_acc  = i_write && !o_full && !i_drop;
      ovf_now = i_write && o_full && !i_drop;
      rd_acc  = i_read && !o_empty;
      cm_rej  = i_commit && !i_drop && (ovf_q || ovf_now);

      wr_d   = wr_acc ? wr_q + ptr_t'(1) : wr_q;
      rd_d   = rd_acc ? rd_q + ptr_t'(1) : rd_q;
      cm_d   = cm_q;
      ovf_d  = ovf_q || ovf_now;
      ferr_d = cm_rej;

      // A rejected commit rewinds exactly like a drop, it just also flags the error.
      if (i_drop || cm_rej) begin
         wr_d  = cm_q;
         ovf_d = 1'b0;
      end else if (i_commit) begin
         cm_d = wr_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q     <= '0;
         cm_q     <= '0;
         rd_q     <= '0;
         ovf_q    <= 1'b0;
         ferr_q   <= 1'b0;
         rvalid_q <= 1'b0;
         data_q   <= '0;
      end else begin
         wr_q     <= wr_d;
         cm_q     <= cm_d;
         rd_q     <= rd_d;
         ovf_q    <= ovf_d;
         ferr_q   <= ferr_d;
         rvalid_q <= rd_acc;
         if (rd_acc) begin
            data_q <= mem_q[rd_q[ADDR_W-1:0]];
         end
      end
   end

   // NOTE: the storage array has no reset so it maps onto a simple dual-port block RAM.
   always_ff @(posedge i_clk) begin
      if (wr_acc && !i_rst) begin
         mem_q[wr_q[ADDR_W-1:0]] <= i_data;
      end
   end

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Self-checking bench for eth_pkt_fifo against a queue-based frame model.
module tb_eth_pkt_fifo;

   localparam int DW   = 8;
   localparam int AW   = 4;
   localparam int DEP  = 16;
   localparam int AFTH = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          write = 1'b0, commit = 1'b0, drop = 1'b0, read = 1'b0;
   logic [DW-1:0] o_data;
   logic          o_rvalid, o_empty, o_full, o_afull, o_frame_err;
   logic [AW:0]   o_used;

   int errors = 0;
   int checks = 0;

   // Reference model: committed and pending words as plain queues.
   logic [DW-1:0] cq[$];
   logic [DW-1:0] pq[$];
   bit            m_ovf;
   logic [DW-1:0] m_data;
   bit            m_rvalid;
   bit            m_ferr;

   eth_pkt_fifo #(.DATA_W(DW), .ADDR_W(AW), .AFULL_TH(AFTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_data(data_in), .i_write(write), .i_commit(commit),
      .i_drop(drop), .o_data(o_data), .o_rvalid(o_rvalid), .i_read(read),
      .o_empty(o_empty), .o_full(o_full), .o_afull(o_afull), .o_used(o_used),
      .o_frame_err(o_frame_err)
   );

   always #5 clk = ~clk;

   function automatic int m_stored();
      return cq.size() + pq.size();
   endfunction

   // Drive one cycle of inputs, advance the model, and return #1 after the edge.
   task automatic cycle(input bit r, input bit w, input logic [DW-1:0] d,
                        input bit c, input bit dr, input bit rd);
      bit full_pre;
      rst = r; write = w; data_in = d; commit = c; drop = dr; read = rd;
      full_pre = (m_stored() == DEP);
      if (r) begin
         cq.delete(); pq.delete();
         m_ovf = 0; m_rvalid = 0; m_data = '0; m_ferr = 0;
      end else begin
         m_ferr = 0;
         if (rd && cq.size() > 0) begin
            m_data   = cq.pop_front();
            m_rvalid = 1;
         end else begin
            m_rvalid = 0;
         end
         if (dr) begin
            pq.delete();
            m_ovf = 0;
         end else begin
            if (w && !full_pre) pq.push_back(d);
            if (w && full_pre) m_ovf = 1;
            if (c) begin
               if (m_ovf) begin
                  pq.delete();
                  m_ovf  = 0;
                  m_ferr = 1;
               end else begin
                  foreach (pq[i]) cq.push_back(pq[i]);
                  pq.delete();
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, '0, 0, 0, 0);
      cycle(1, 0, '0, 0, 0, 0);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
      checks++; if (o_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", o_afull); end
      checks++; if (o_used !== 5'd0) begin errors++; $display("FAIL reset_used: got %0d want 0", o_used); end
      checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", o_rvalid); end
      checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
      checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 8'(8'h10 + i), i == 4, 0, 0);
         if (i < 4) begin
            checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_pending_hidden: got empty=%b want 1", o_empty); end
         end
      end
      checks++; if (o_used !== 5'd5) begin errors++; $display("FAIL basic_used: got %0d want 5", o_used); end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, '0, 0, 0, 1);
         checks++; if (o_rvalid !== 1'b1) begin errors++; $display("FAIL basic_rvalid: got %b want 1", o_rvalid); end
         checks++; if (o_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL basic_data: got %h want %h", o_data, 8'(8'h10 + i)); end
      end
      cycle(0, 0, '0, 0, 0, 0);
      checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL basic_idle_rvalid: got %b want 0", o_rvalid); end
      checks++; if (o_data !== 8'h14) begin errors++; $display("FAIL basic_data_hold: got %h want 14", o_data); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", o_empty); end
   endtask

   task automatic test_drop();
      for (int i = 0; i < 4; i++) cycle(0, 1, 8'($urandom), 0, 0, 0);
      cycle(0, 0, '0, 0, 1, 1);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL drop_empty: got %b want 1", o_empty); end
      checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL drop_rvalid: got %b want 0", o_rvalid); end
      for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'hA0 + i), i == 2, 0, 0);
      checks++; if (o_used !== 5'd3) begin errors++; $display("FAIL drop_next_used: got %0d want 3", o_used); end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, '0, 0, 0, 1);
         checks++; if (o_rvalid !== 1'b1 || o_data !== 8'(8'hA0 + i)) begin
            errors++; $display("FAIL drop_next_data: got v=%b %h want v=1 %h", o_rvalid, o_data, 8'(8'hA0 + i));
         end
      end
      cycle(0, 0, '0, 0, 0, 1);
      checks++; if (o_rvalid !== 1'b0 || o_empty !== 1'b1) begin
         errors++; $display("FAIL drop_drained: got v=%b empty=%b want v=0 empty=1", o_rvalid, o_empty);
      end
   endtask

   task automatic test_overflow();
      int pulses = 0;
      for (int i = 1; i <= 17; i++) begin
         cycle(0, 1, 8'(i), 0, 0, 0);
         checks++; if (o_full !== (i >= 16)) begin errors++; $display("FAIL ovf_full: write %0d got %b want %b", i, o_full, i >= 16); end
         checks++; if (o_afull !== (i >= 12)) begin errors++; $display("FAIL ovf_afull: write %0d got %b want %b", i, o_afull, i >= 12); end
         checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: write %0d got %b want 1", i, o_empty); end
      end
      cycle(0, 0, '0, 1, 0, 0);
      if (o_frame_err === 1'b1) pulses++;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, '0, 0, 0, 0);
         if (o_frame_err === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ovf_ferr_pulses: got %0d want 1", pulses); end
      checks++; if (o_empty !== 1'b1 || o_full !== 1'b0 || o_afull !== 1'b0) begin
         errors++; $display("FAIL ovf_after: got empty=%b full=%b afull=%b want 1 0 0", o_empty, o_full, o_afull);
      end
   endtask

   task automatic test_wrap();
      int max_used = 0;
      for (int f = 0; f < 31; f++) begin
         for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 8'($urandom), k == 2, 0, f > 0);
            if (int'(o_used) > max_used) max_used = int'(o_used);
            checks++; if (o_rvalid !== m_rvalid || (m_rvalid && o_data !== m_data)) begin
               errors++; $display("FAIL wrap_data: got v=%b %h want v=%b %h", o_rvalid, o_data, m_rvalid, m_data);
            end
            checks++; if (o_used !== 5'(cq.size())) begin
               errors++; $display("FAIL wrap_used: got %0d want %0d", o_used, cq.size());
            end
         end
      end
      for (int n = 0; n < 40 && cq.size() > 0; n++) begin
         cycle(0, 0, '0, 0, 0, 1);
         checks++; if (o_rvalid !== 1'b1 || o_data !== m_data) begin
            errors++; $display("FAIL wrap_drain: got v=%b %h want v=1 %h", o_rvalid, o_data, m_data);
         end
      end
      checks++; if (o_empty !== 1'b1 || cq.size() != 0) begin
         errors++; $display("FAIL wrap_end_empty: got %b want 1", o_empty);
      end
      checks++; if (max_used > DEP) begin errors++; $display("FAIL wrap_max_used: got %0d want <=16", max_used); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) cycle(0, 1, 8'($urandom), i == 5, 0, 0);
      cycle(0, 1, 8'h55, 0, 0, 0);
      cycle(0, 1, 8'h66, 0, 0, 0);
      checks++; if (o_used !== 5'd6) begin errors++; $display("FAIL rstmid_pre_used: got %0d want 6", o_used); end
      cycle(1, 1, 8'h77, 1, 0, 1);
      checks++; if (o_empty !== 1'b1 || o_used !== 5'd0 || o_rvalid !== 1'b0) begin
         errors++; $display("FAIL rstmid_state: got empty=%b used=%0d v=%b want 1 0 0", o_empty, o_used, o_rvalid);
      end
      cycle(0, 0, '0, 0, 0, 1);
      checks++; if (o_rvalid !== 1'b0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
         errors++; $display("FAIL rstmid_read_ignored: got v=%b empty=%b full=%b want 0 1 0", o_rvalid, o_empty, o_full);
      end
   endtask

   task automatic test_commit_drop();
      for (int i = 0; i < 3; i++) cycle(0, 1, 8'($urandom), 0, 0, 0);
      cycle(0, 1, 8'h99, 1, 1, 0);
      checks++; if (o_frame_err !== 1'b0 || o_empty !== 1'b1 || o_used !== 5'd0) begin
         errors++; $display("FAIL cmdrop: got ferr=%b empty=%b used=%0d want 0 1 0", o_frame_err, o_empty, o_used);
      end
      cycle(0, 1, 8'h3C, 1, 0, 0);
      cycle(0, 0, '0, 0, 0, 1);
      checks++; if (o_rvalid !== 1'b1 || o_data !== 8'h3C || o_frame_err !== 1'b0) begin
         errors++; $display("FAIL cmdrop_next: got v=%b %h ferr=%b want 1 3c 0", o_rvalid, o_data, o_frame_err);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         cycle(0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
         checks++;
         if (o_rvalid !== m_rvalid || o_data !== m_data || o_frame_err !== m_ferr ||
             o_used !== 5'(cq.size()) || o_empty !== (cq.size() == 0) ||
             o_full !== (m_stored() == DEP) || o_afull !== (m_stored() >= AFTH)) begin
            errors++;
            $display("FAIL random cyc %0d: got v=%b d=%h fe=%b u=%0d e=%b f=%b af=%b want v=%b d=%h fe=%b u=%0d e=%b f=%b af=%b",
                     n, o_rvalid, o_data, o_frame_err, o_used, o_empty, o_full, o_afull,
                     m_rvalid, m_data, m_ferr, cq.size(), cq.size() == 0, m_stored() == DEP, m_stored() >= AFTH);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_overflow();
      test_wrap();
      test_reset_mid();
      test_commit_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
